rob_commit_unit: RTL and testbench

8-entry in-order reorder buffer that closes the loop for the execution pipes. It allocates instruction ids to decode and accepts out-of-order writebacks from the ALU and multiply pipes. It answers the pipes' source-operand lookups with `src*_hit`/`src*_data`. It retires entries in program order to the register file and raises a precise exception plus a pipeline flush when the head entry carries an exception.

---
 rtl/rob_commit_unit.sv | 192 +++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// 8-entry in-order reorder buffer: allocates ids, takes out-of-order writebacks, forwards results, retires in order.
// Retire is 2 cycles after the head writeback; alloc_ready drops when full or while an exception commits.
module rob_commit_unit #(
  parameter int ENTRIES = 8,
  localparam int IDW = $clog2(ENTRIES)
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [IDW-1:0]  alloc_id,

  input  logic            wb0_valid,
  input  logic [IDW-1:0]  wb0_instr_id,
  input  logic [31:0]     wb0_pc,
  input  logic            wb0_rd_write,
  input  logic [4:0]      wb0_rd_addr,
  input  logic [31:0]     wb0_rd_data,
  input  logic            wb0_xcpt_valid,
  input  logic [3:0]      wb0_xcpt_cause,

  input  logic            wb1_valid,
  input  logic [IDW-1:0]  wb1_instr_id,
  input  logic [31:0]     wb1_pc,
  input  logic            wb1_rd_write,
  input  logic [4:0]      wb1_rd_addr,
  input  logic [31:0]     wb1_rd_data,
  input  logic            wb1_xcpt_valid,
  input  logic [3:0]      wb1_xcpt_cause,

  input  logic [IDW-1:0]  src1_id,
  input  logic [IDW-1:0]  src2_id,
  output logic            src1_hit,
  output logic            src2_hit,
  output logic [31:0]     src1_data,
  output logic [31:0]     src2_data,

  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [31:0]     rf_wr_data,

  output logic            xcpt_valid,
  output logic [31:0]     xcpt_pc,
  output logic [3:0]      xcpt_cause,
  output logic            flush
);

  localparam int CNTW = IDW + 1;

  typedef struct packed {
    logic        alloc;
    logic        done;
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pc;
    logic        xcpt;
    logic [3:0]  cause;
  } rob_entry_t;

  rob_entry_t          entries [ENTRIES];
  logic [IDW-1:0]      head;
  logic [IDW-1:0]      tail;
  logic [CNTW-1:0]     count;

  rob_entry_t          head_entry;
  logic                commit_fire;
  logic                commit_ok;
  logic                commit_xcpt;
  logic                alloc_fire;
  logic                wb0_ok;
  logic                wb1_ok;
  logic                wb_same_id;

  function automatic logic fwd_hit(input rob_entry_t e);
    return e.alloc & e.done & e.rd_write & ~e.xcpt;
  endfunction

  function automatic rob_entry_t wb_fill(
    input logic [31:0] pc,
    input logic        rd_write,
    input logic [4:0]  rd_addr,
    input logic [31:0] rd_data,
    input logic        xcpt,
    input logic [3:0]  cause
  );
    rob_entry_t e;
    e.alloc    = 1'b1;
    e.done     = 1'b1;
    e.rd_write = rd_write;
    e.rd_addr  = rd_addr;
    e.rd_data  = rd_data;
    e.pc       = pc;
    e.xcpt     = xcpt;
    e.cause    = cause;
    return e;
  endfunction

  assign head_entry  = entries[head];
  assign commit_fire = (count != '0) & head_entry.done;
  assign commit_xcpt = commit_fire & head_entry.xcpt;
  assign commit_ok   = commit_fire & ~head_entry.xcpt;

  assign alloc_ready = (count != CNTW'(ENTRIES)) & ~commit_xcpt;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_id    = tail;

  // Port 0 owns the entry on a same-id collision, whether or not its own write lands.
  assign wb_same_id = wb0_valid & (wb0_instr_id == wb1_instr_id);
  assign wb0_ok     = wb0_valid & entries[wb0_instr_id].alloc & ~entries[wb0_instr_id].done;
  assign wb1_ok     = wb1_valid & ~wb_same_id
                    & entries[wb1_instr_id].alloc & ~entries[wb1_instr_id].done;

  assign src1_hit  = fwd_hit(entries[src1_id]);
  assign src2_hit  = fwd_hit(entries[src2_id]);
  assign src1_data = src1_hit ? entries[src1_id].rd_data : 32'h0;
  assign src2_data = src2_hit ? entries[src2_id].rd_data : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      xcpt_valid <= 1'b0;
      xcpt_pc    <= '0;
      xcpt_cause <= '0;
      flush      <= 1'b0;
    end else begin
      rf_wr_en   <= commit_ok & head_entry.rd_write;
      xcpt_valid <= commit_xcpt;
      flush      <= commit_xcpt;
      if (commit_ok) begin
        rf_wr_addr <= head_entry.rd_addr;
        rf_wr_data <= head_entry.rd_data;
      end

      if (commit_xcpt) begin
        // Precise exception: drop every younger entry and any same-cycle alloc/writeback.
        xcpt_pc    <= head_entry.pc;
        xcpt_cause <= head_entry.cause;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        for (int i = 0; i < ENTRIES; i++) begin
          entries[i].alloc <= 1'b0;
          entries[i].done  <= 1'b0;
        end
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (wb0_ok && wb0_instr_id == IDW'(i)) begin
            entries[i] <= wb_fill(wb0_pc, wb0_rd_write, wb0_rd_addr, wb0_rd_data,
                                  wb0_xcpt_valid, wb0_xcpt_cause);
          end else if (wb1_ok && wb1_instr_id == IDW'(i)) begin
            entries[i] <= wb_fill(wb1_pc, wb1_rd_write, wb1_rd_addr, wb1_rd_data,
                                  wb1_xcpt_valid, wb1_xcpt_cause);
          end
        end

        if (commit_ok) begin
          entries[head].alloc <= 1'b0;
          entries[head].done  <= 1'b0;
          head                <= head + IDW'(1);
        end

        if (alloc_fire) begin
          entries[tail].alloc <= 1'b1;
          entries[tail].done  <= 1'b0;
          tail                <= tail + IDW'(1);
        end

        if (alloc_fire && !commit_ok) begin
          count <= count + CNTW'(1);
        end else if (commit_ok && !alloc_fire) begin
          count <= count - CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count <= CNTW'(ENTRIES));
      assert (!(rf_wr_en && xcpt_valid));
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: fill, out-of-order retire, forwarding, exception, collision/wrap, mid-run reset.
module tb_rob_commit_unit;

  logic        clock;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_id;
  logic        wb0_valid, wb1_valid;
  logic [2:0]  wb0_instr_id, wb1_instr_id;
  logic [31:0] wb0_pc, wb1_pc;
  logic        wb0_rd_write, wb1_rd_write;
  logic [4:0]  wb0_rd_addr, wb1_rd_addr;
  logic [31:0] wb0_rd_data, wb1_rd_data;
  logic        wb0_xcpt_valid, wb1_xcpt_valid;
  logic [3:0]  wb0_xcpt_cause, wb1_xcpt_cause;
  logic [2:0]  src1_id, src2_id;
  logic        src1_hit, src2_hit;
  logic [31:0] src1_data, src2_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        xcpt_valid;
  logic [31:0] xcpt_pc;
  logic [3:0]  xcpt_cause;
  logic        flush;

  int checks;
  int failures;

  rob_commit_unit dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb0_valid(wb0_valid), .wb0_instr_id(wb0_instr_id), .wb0_pc(wb0_pc),
    .wb0_rd_write(wb0_rd_write), .wb0_rd_addr(wb0_rd_addr), .wb0_rd_data(wb0_rd_data),
    .wb0_xcpt_valid(wb0_xcpt_valid), .wb0_xcpt_cause(wb0_xcpt_cause),
    .wb1_valid(wb1_valid), .wb1_instr_id(wb1_instr_id), .wb1_pc(wb1_pc),
    .wb1_rd_write(wb1_rd_write), .wb1_rd_addr(wb1_rd_addr), .wb1_rd_data(wb1_rd_data),
    .wb1_xcpt_valid(wb1_xcpt_valid), .wb1_xcpt_cause(wb1_xcpt_cause),
    .src1_id(src1_id), .src2_id(src2_id),
    .src1_hit(src1_hit), .src2_hit(src2_hit),
    .src1_data(src1_data), .src2_data(src2_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .xcpt_cause(xcpt_cause),
    .flush(flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wb0(input logic [2:0] id, input logic [31:0] pc, input logic rdw,
                         input logic [4:0] rd, input logic [31:0] data,
                         input logic x, input logic [3:0] cause);
    wb0_valid = 1'b1; wb0_instr_id = id; wb0_pc = pc; wb0_rd_write = rdw;
    wb0_rd_addr = rd; wb0_rd_data = data; wb0_xcpt_valid = x; wb0_xcpt_cause = cause;
  endtask

  task automatic set_wb1(input logic [2:0] id, input logic [31:0] pc, input logic rdw,
                         input logic [4:0] rd, input logic [31:0] data,
                         input logic x, input logic [3:0] cause);
    wb1_valid = 1'b1; wb1_instr_id = id; wb1_pc = pc; wb1_rd_write = rdw;
    wb1_rd_addr = rd; wb1_rd_data = data; wb1_xcpt_valid = x; wb1_xcpt_cause = cause;
  endtask

  task automatic idle_wb();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
  endtask

  task automatic alloc_n(input int n, input logic [2:0] first_id, input string tag);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      #1;
      check_val(tag, {29'h0, alloc_id}, {29'h0, 3'(first_id + 3'(i))});
      tick();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_rf(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check_val({tag, "_en"}, {31'h0, rf_wr_en}, {31'h0, en});
    if (en) begin
      check_val({tag, "_addr"}, {27'h0, rf_wr_addr}, {27'h0, addr});
      check_val({tag, "_data"}, rf_wr_data, data);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    alloc_valid = 1'b0;
    src1_id = 3'd0; src2_id = 3'd0;
    wb0_instr_id = '0; wb0_pc = '0; wb0_rd_write = 1'b0; wb0_rd_addr = '0;
    wb0_rd_data = '0; wb0_xcpt_valid = 1'b0; wb0_xcpt_cause = '0;
    wb1_instr_id = '0; wb1_pc = '0; wb1_rd_write = 1'b0; wb1_rd_addr = '0;
    wb1_rd_data = '0; wb1_xcpt_valid = 1'b0; wb1_xcpt_cause = '0;
    idle_wb();

    // reset state
    tick();
    tick();
    check_val("rst_rf_wr_en", {31'h0, rf_wr_en}, 32'h0);
    check_val("rst_xcpt_valid", {31'h0, xcpt_valid}, 32'h0);
    check_val("rst_flush", {31'h0, flush}, 32'h0);
    check_val("rst_alloc_ready", {31'h0, alloc_ready}, 32'h1);
    check_val("rst_alloc_id", {29'h0, alloc_id}, 32'h0);
    check_val("rst_src1_hit", {31'h0, src1_hit}, 32'h0);
    check_val("rst_src1_data", src1_data, 32'h0);
    reset = 1'b0;

    // fill: ids 0..7 then stall
    alloc_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_val("fill_ready", {31'h0, alloc_ready}, (i < 8) ? 32'h1 : 32'h0);
      check_val("fill_id", {29'h0, alloc_id}, (i < 8) ? i : 0);
      tick();
    end
    alloc_valid = 1'b0;
    check_val("fill_full_ready", {31'h0, alloc_ready}, 32'h0);
    check_val("fill_no_rf", {31'h0, rf_wr_en}, 32'h0);

    // out-of-order completion, in-order retire
    apply_reset();
    alloc_n(3, 3'd0, "ooo_alloc_id");
    set_wb0(3'd2, 32'h208, 1'b1, 5'd3, 32'h33, 1'b0, 4'h0);
    tick();
    idle_wb();
    check_val("ooo_no_rf_a", {31'h0, rf_wr_en}, 32'h0);
    set_wb1(3'd1, 32'h204, 1'b1, 5'd2, 32'h22, 1'b0, 4'h0);
    tick();
    idle_wb();
    check_val("ooo_no_rf_b", {31'h0, rf_wr_en}, 32'h0);
    set_wb0(3'd0, 32'h200, 1'b1, 5'd1, 32'h11, 1'b0, 4'h0);
    tick();
    idle_wb();
    check_val("ooo_no_rf_c", {31'h0, rf_wr_en}, 32'h0);
    tick();
    check_rf("ooo_r0", 1'b1, 5'd1, 32'h11);
    tick();
    check_rf("ooo_r1", 1'b1, 5'd2, 32'h22);
    tick();
    check_rf("ooo_r2", 1'b1, 5'd3, 32'h33);
    tick();
    check_rf("ooo_idle", 1'b0, 5'd0, 32'h0);

    // forwarding: ids 3 (rd_write=0) and 4 (rd_write=1)
    alloc_n(2, 3'd3, "fwd_alloc_id");
    src1_id = 3'd4;
    src2_id = 3'd3;
    set_wb0(3'd4, 32'h310, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0);
    #1;
    check_val("fwd_hit_wb_cycle", {31'h0, src1_hit}, 32'h0);
    tick();
    idle_wb();
    #1;
    check_val("fwd_hit_next", {31'h0, src1_hit}, 32'h1);
    check_val("fwd_data_next", src1_data, 32'hDEADBEEF);
    check_val("fwd_no_retire", {31'h0, rf_wr_en}, 32'h0);
    set_wb0(3'd3, 32'h30c, 1'b0, 5'd6, 32'h12345678, 1'b0, 4'h0);
    tick();
    idle_wb();
    #1;
    check_val("fwd_nowrite_hit", {31'h0, src2_hit}, 32'h0);
    check_val("fwd_nowrite_data", src2_data, 32'h0);
    tick();
    check_rf("fwd_r3", 1'b0, 5'd0, 32'h0);
    tick();
    check_rf("fwd_r4", 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check_val("fwd_hit_retired", {31'h0, src1_hit}, 32'h0);

    // precise exception
    apply_reset();
    alloc_n(2, 3'd0, "xc_alloc_id");
    set_wb0(3'd1, 32'h1004, 1'b1, 5'd7, 32'h77, 1'b0, 4'h0);
    tick();
    idle_wb();
    set_wb0(3'd0, 32'h1000, 1'b1, 5'd8, 32'h88, 1'b1, 4'h5);
    tick();
    idle_wb();
    check_val("xc_pre_valid", {31'h0, xcpt_valid}, 32'h0);
    check_val("xc_pre_ready", {31'h0, alloc_ready}, 32'h0);
    tick();
    check_val("xc_valid", {31'h0, xcpt_valid}, 32'h1);
    check_val("xc_flush", {31'h0, flush}, 32'h1);
    check_val("xc_pc", xcpt_pc, 32'h1000);
    check_val("xc_cause", {28'h0, xcpt_cause}, 32'h5);
    check_val("xc_rf_en", {31'h0, rf_wr_en}, 32'h0);
    check_val("xc_alloc_id", {29'h0, alloc_id}, 32'h0);
    check_val("xc_alloc_ready", {31'h0, alloc_ready}, 32'h1);
    tick();
    check_val("xc_valid_drop", {31'h0, xcpt_valid}, 32'h0);
    check_val("xc_flush_drop", {31'h0, flush}, 32'h0);
    tick();
    check_val("xc_no_rf_id1", {31'h0, rf_wr_en}, 32'h0);
    check_val("xc_next_id", {29'h0, alloc_id}, 32'h0);

    // wb port collision on id3
    alloc_n(4, 3'd0, "col_alloc_id");
    src1_id = 3'd3;
    set_wb0(3'd3, 32'h40c, 1'b1, 5'd8, 32'hAAAA, 1'b0, 4'h0);
    set_wb1(3'd3, 32'h40c, 1'b1, 5'd9, 32'hBBBB, 1'b0, 4'h0);
    tick();
    idle_wb();
    #1;
    check_val("col_fwd_data", src1_data, 32'hAAAA);
    set_wb0(3'd0, 32'h400, 1'b1, 5'd10, 32'h10, 1'b0, 4'h0);
    set_wb1(3'd1, 32'h404, 1'b1, 5'd11, 32'h11, 1'b0, 4'h0);
    tick();
    idle_wb();
    set_wb0(3'd2, 32'h408, 1'b1, 5'd12, 32'h12, 1'b0, 4'h0);
    tick();
    idle_wb();
    check_rf("col_r0", 1'b1, 5'd10, 32'h10);
    tick();
    check_rf("col_r1", 1'b1, 5'd11, 32'h11);
    tick();
    check_rf("col_r2", 1'b1, 5'd12, 32'h12);
    tick();
    check_rf("col_r3", 1'b1, 5'd8, 32'hAAAA);
    tick();
    check_rf("col_idle", 1'b0, 5'd0, 32'h0);

    // 20 alloc/retire pairs starting at id4, ids wrap
    for (int i = 0; i < 20; i++) begin
      alloc_valid = 1'b1;
      if (i > 0) set_wb0(3'(4 + i - 1), 32'h500, 1'b1, 5'd6, 32'h100 + i - 1, 1'b0, 4'h0);
      #1;
      check_val("wrap_id", {29'h0, alloc_id}, (4 + i) % 8);
      check_val("wrap_ready", {31'h0, alloc_ready}, 32'h1);
      if (i >= 3) check_rf("wrap_rf", 1'b1, 5'd6, 32'h100 + i - 3);
      else check_rf("wrap_rf_warm", 1'b0, 5'd0, 32'h0);
      tick();
      idle_wb();
    end
    alloc_valid = 1'b0;
    check_rf("wrap_r17", 1'b1, 5'd6, 32'h111);
    set_wb0(3'd7, 32'h500, 1'b1, 5'd6, 32'h113, 1'b0, 4'h0);
    tick();
    idle_wb();
    check_rf("wrap_r18", 1'b1, 5'd6, 32'h112);
    tick();
    check_rf("wrap_r19", 1'b1, 5'd6, 32'h113);
    tick();
    check_rf("wrap_drained", 1'b0, 5'd0, 32'h0);
    check_val("wrap_end_id", {29'h0, alloc_id}, 32'h0);

    // reset with 5 in flight, 2 done (not head)
    alloc_n(5, 3'd0, "mid_alloc_id");
    set_wb0(3'd1, 32'h600, 1'b1, 5'd13, 32'h61, 1'b0, 4'h0);
    set_wb1(3'd2, 32'h604, 1'b1, 5'd14, 32'h62, 1'b0, 4'h0);
    tick();
    idle_wb();
    src1_id = 3'd1;
    src2_id = 3'd2;
    #1;
    check_val("mid_pre_hit1", {31'h0, src1_hit}, 32'h1);
    check_val("mid_pre_ready", {31'h0, alloc_ready}, 32'h1);
    reset = 1'b1;
    tick();
    check_val("mid_rst_rf", {31'h0, rf_wr_en}, 32'h0);
    reset = 1'b0;
    tick();
    check_val("mid_rf", {31'h0, rf_wr_en}, 32'h0);
    check_val("mid_alloc_id", {29'h0, alloc_id}, 32'h0);
    check_val("mid_alloc_ready", {31'h0, alloc_ready}, 32'h1);
    check_val("mid_hit1", {31'h0, src1_hit}, 32'h0);
    check_val("mid_hit2", {31'h0, src2_hit}, 32'h0);
    tick();
    check_val("mid_rf_later", {31'h0, rf_wr_en}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
